// File: rtl/mole_pkg.sv
// Shared constants for the PS/2 mole-game keyboard front end: scan codes,
// the datapath's 3-bit hit encoding, and the PS/2 frame receiver state enum.
package mole_pkg;

  localparam logic [7:0] KEY_1     = 8'h16;
  localparam logic [7:0] KEY_2     = 8'h1E;
  localparam logic [7:0] KEY_3     = 8'h26;
  localparam logic [7:0] KEY_4     = 8'h25;
  localparam logic [7:0] KEY_5     = 8'h2E;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;

  localparam logic [2:0] HIT_NONE = 3'd0;
  localparam logic [2:0] HIT_M1   = 3'd1;
  localparam logic [2:0] HIT_M2   = 3'd2;
  localparam logic [2:0] HIT_M3   = 3'd3;
  localparam logic [2:0] HIT_M4   = 3'd4;
  localparam logic [2:0] HIT_M5   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic logic [2:0] key_to_hit(input logic [7:0] sc);
    case (sc)
      KEY_1:   key_to_hit = HIT_M1;
      KEY_2:   key_to_hit = HIT_M2;
      KEY_3:   key_to_hit = HIT_M3;
      KEY_4:   key_to_hit = HIT_M4;
      KEY_5:   key_to_hit = HIT_M5;
      default: key_to_hit = HIT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin sync, falling-edge detect, 11-bit frame FSM, timeout.
// Optional odd-parity check when PS2_PARITY_CHECK_EN is defined.
module ps2_frame_rx
  import mole_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       err_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_s_q, dat_s_q;
  logic          clk_prev_q;
  rx_state_e     state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;

  logic fall, dat, stop_edge, tmo_hit, par_bad;

  assign fall      = clk_prev_q & ~clk_s_q[1];
  assign dat       = dat_s_q[1];
  assign stop_edge = (state_q == ST_STOP) & fall;
  assign tmo_hit   = (state_q != ST_IDLE) & ~fall & (tmo_q == TMO_MAX);

`ifdef PS2_PARITY_CHECK_EN
  assign par_bad = stop_edge & dat & ~(^{shift_q, par_q});
`else
  logic unused_par;
  assign unused_par = par_q;
  assign par_bad    = 1'b0;
`endif

  // Outputs are combinational in the stop-edge cycle so the top can register
  // its pulses exactly one cycle later.
  assign byte_valid_o = stop_edge & dat & ~par_bad;
  assign byte_o       = shift_q;
  assign err_o        = (stop_edge & ~dat) | par_bad | tmo_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_s_q    <= 2'b11;
      dat_s_q    <= 2'b11;
      clk_prev_q <= 1'b1;
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      clk_s_q    <= {clk_s_q[0], ps2_clk};
      dat_s_q    <= {dat_s_q[0], ps2_dat};
      clk_prev_q <= clk_s_q[1];
      if (state_q == ST_IDLE) begin
        tmo_q <= '0;
        if (fall && !dat) begin
          state_q   <= ST_DATA;
          bit_cnt_q <= 3'd0;
        end
      end else if (fall) begin
        tmo_q <= '0;
        case (state_q)
          ST_DATA: begin
            shift_q   <= {dat, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            par_q   <= dat;
            state_q <= ST_STOP;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (tmo_q == TMO_MAX) begin
        tmo_q   <= '0;
        state_q <= ST_IDLE;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_mole_input.sv
// PS/2 keyboard front end for the mole game: make/break decode, one hit pulse
// per press, Enter start pulse. Build option: PS2_PARITY_CHECK_EN (parity check).
module ps2_mole_input
  import mole_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [2:0] hit_code,
  output logic       start_key,
  output logic       frame_err
);

  logic       rx_valid, rx_err;
  logic [7:0] rx_byte;

  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clock        (clock),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_dat      (ps2_dat),
    .byte_valid_o (rx_valid),
    .byte_o       (rx_byte),
    .err_o        (rx_err)
  );

  logic       brk_q, brk_d, ext_q, ext_d;
  logic [7:0] held_q, held_d;
  logic [2:0] hit_q, hit_d;
  logic       start_q, start_d, err_q, err_d;
  logic [2:0] code;

  assign code = key_to_hit(rx_byte);

  always_comb begin
    brk_d   = brk_q;
    ext_d   = ext_q;
    held_d  = held_q;
    hit_d   = HIT_NONE;
    start_d = 1'b0;
    err_d   = rx_err;
    if (rx_valid) begin
      if (rx_byte == SC_BREAK) begin
        brk_d = 1'b1;
      end else if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (ext_q) begin
        // Extended keys (arrows, keypad Enter...) are not game inputs.
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else if (brk_q) begin
        if (rx_byte == held_q) held_d = 8'h00;
        brk_d = 1'b0;
      end else begin
        // Typematic repeats of the held mole key must not score again.
        if (code != HIT_NONE && rx_byte != held_q) begin
          hit_d  = code;
          held_d = rx_byte;
        end
        if (rx_byte == KEY_ENTER) start_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      brk_q   <= 1'b0;
      ext_q   <= 1'b0;
      held_q  <= 8'h00;
      hit_q   <= HIT_NONE;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      brk_q   <= brk_d;
      ext_q   <= ext_d;
      held_q  <= held_d;
      hit_q   <= hit_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  assign hit_code  = hit_q;
  assign start_key = start_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_mole_input.sv
// Scoreboard bench for ps2_mole_input: stimulus pushes expected pulses with
// their expected cycle; a negedge monitor pops and compares every output pulse.
module tb_ps2_mole_input;

  localparam int K_HIT = 1, K_START = 2, K_ERR = 3;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [2:0] hit_code;
  logic       start_key;
  logic       frame_err;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  ps2_mole_input #(.TIMEOUT_CYCLES(200)) dut (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .hit_code  (hit_code),
    .start_key (start_key),
    .frame_err (frame_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic push(input int kind, input int val, input int c);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  // nbits < 11 sends a truncated frame; expectation is queued at the stop edge.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop,
                            input int nbits, input int ek, input int ev);
    logic [10:0] bits;
    bits = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      repeat (20) @(posedge clock);
      #1 ps2_clk = 1'b0;
      if (i == 10 && ek != 0) push(ek, ev, cyc + 3);
      repeat (20) @(posedge clock);
      #1 ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    repeat (20) @(posedge clock);
  endtask

  task automatic check_idle(input string name);
    n_checks++;
    if (hit_code !== 3'd0 || start_key !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: hit=%0d start=%0b err=%0b, required all 0", name, hit_code,
               start_key, frame_err);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && (hit_code !== 3'd0 || start_key !== 1'b0 || frame_err !== 1'b0)) begin
      int   ak, av, nact;
      exp_t e;
      nact = int'(hit_code != 3'd0) + int'(start_key) + int'(frame_err);
      ak   = frame_err ? K_ERR : (start_key ? K_START : K_HIT);
      av   = frame_err ? 1 : (start_key ? 1 : int'(hit_code));
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: cycle %0d kind=%0d val=%0d, required none", cyc, ak, av);
      end else begin
        e = sb.pop_front();
        if (nact != 1 || ak != e.kind || av != e.val || (e.cyc >= 0 && cyc != e.cyc)) begin
          n_fail++;
          $display("FAIL pulse: got kind=%0d val=%0d cycle=%0d active=%0d, required kind=%0d val=%0d cycle=%0d",
                   ak, av, cyc, nact, e.kind, e.val, e.cyc);
        end
      end
    end
  end

  initial begin
    repeat (5) @(posedge clock);
    @(negedge clock) check_idle("reset_state");
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock) check_idle("after_reset");

    // 1: press/release key 2
    send_frame(8'h1E, 0, 1, 11, K_HIT, 2);
    send_frame(8'hF0, 0, 1, 11, 0, 0);
    send_frame(8'h1E, 0, 1, 11, 0, 0);

    // 2: typematic key 5, then release and re-press
    send_frame(8'h2E, 0, 1, 11, K_HIT, 5);
    send_frame(8'h2E, 0, 1, 11, 0, 0);
    send_frame(8'h2E, 0, 1, 11, 0, 0);
    send_frame(8'hF0, 0, 1, 11, 0, 0);
    send_frame(8'h2E, 0, 1, 11, 0, 0);
    send_frame(8'h2E, 0, 1, 11, K_HIT, 5);

    // 3: Enter, extended key 1, unmapped byte
    send_frame(8'h5A, 0, 1, 11, K_START, 1);
    send_frame(8'hE0, 0, 1, 11, 0, 0);
    send_frame(8'h16, 0, 1, 11, 0, 0);
    send_frame(8'h33, 0, 1, 11, 0, 0);

    // 4: bad stop bit, truncated frame timeout, then good key 1
    send_frame(8'h16, 0, 0, 11, K_ERR, 1);
    push(K_ERR, 1, -1);
    send_frame(8'h16, 0, 1, 5, 0, 0);
    repeat (300) @(posedge clock);
    send_frame(8'h16, 0, 1, 11, K_HIT, 1);

    // 5: key 3 with wrong parity
`ifdef PS2_PARITY_CHECK_EN
    send_frame(8'h26, 1, 1, 11, K_ERR, 1);
`else
    send_frame(8'h26, 1, 1, 11, K_HIT, 3);
`endif

    // 6: reset mid-frame, then full key 4
    send_frame(8'h25, 0, 1, 5, 0, 0);
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock) check_idle("mid_frame_reset");
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (300) @(posedge clock);
    @(negedge clock) check_idle("after_mid_frame_reset");
    send_frame(8'h25, 0, 1, 11, K_HIT, 4);

    repeat (100) @(posedge clock);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
